// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, binary index and valid.
// Optional hold-limit rotation is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state_r, state_s;
   logic [2:0] ptr_r, ptr_s;
   logic [2:0] owner_r, owner_s;
   logic [7:0] gnt_r;
   logic [2:0] gnt_id_r;
   logic       gnt_valid_r;
   logic [7:0] others_s;
   logic [3:0] pick_all_s;
   logic [3:0] pick_oth_s;
   logic       force_s;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD must be in 2..255");
   end

   // First set bit of r scanning start, start+1, ... modulo 8; bit 3 flags a hit.
   function automatic logic [3:0] pick_next(input logic [7:0] r, input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         res = r[idx] ? {1'b1, idx} : res;
      end
      return res;
   endfunction

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt_r;

   assign force_s = (hold_cnt_r == HOLD_LAST) && pick_oth_s[3];

   // Consecutive-cycle counter for the current holder, saturating at HOLD_LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_r <= 8'd0;
      end else if (state_s == IDLE) begin
         hold_cnt_r <= 8'd0;
      end else if (state_r == IDLE || owner_s != owner_r) begin
         hold_cnt_r <= 8'd0;
      end else if (hold_cnt_r != HOLD_LAST) begin
         hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
         hold_cnt_r <= hold_cnt_r;
      end
   end
`else
   assign force_s = 1'b0;
`endif

   // Next-state selection: new grant from idle, handoff on release or forced rotation, else hold.
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      owner_s    = owner_r;
      others_s   = req & ~(8'h01 << owner_r);
      pick_all_s = pick_next(req, ptr_r);
      pick_oth_s = pick_next(others_s, ptr_r);
      case (state_r)
         IDLE: begin
            if (pick_all_s[3]) begin
               state_s = GRANT;
               owner_s = pick_all_s[2:0];
               ptr_s   = pick_all_s[2:0] + 3'd1;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (!req[owner_r] || force_s) begin
               if (pick_oth_s[3]) begin
                  owner_s = pick_oth_s[2:0];
                  ptr_s   = pick_oth_s[2:0] + 3'd1;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = GRANT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, pointer, owner and registered outputs all advance together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         ptr_r       <= 3'd0;
         owner_r     <= 3'd0;
         gnt_r       <= 8'h00;
         gnt_id_r    <= 3'd0;
         gnt_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         owner_r     <= owner_s;
         gnt_r       <= (state_s == GRANT) ? (8'h01 << owner_s) : 8'h00;
         gnt_id_r    <= (state_s == GRANT) ? owner_s : 3'd0;
         gnt_valid_r <= (state_s == GRANT);
      end
   end

   assign gnt       = gnt_r;
   assign gnt_id    = gnt_id_r;
   assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, hold-limit sequences,
// and randomized traffic against a queue-free behavioural model of round-robin arbitration.
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;

   int errors = 0;
   int checks = 0;

   // Model state: owner -1 means no grant; held counts granted cycles including the first.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] id;
      logic       valid;
   } vec_t;

   vec_t vecs[$];

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   always #5 clk = ~clk;

   function automatic int first_from(input logic [7:0] r, input int start);
      for (int off = 0; off < 8; off++) begin
         if (r[(start + off) % 8]) return (start + off) % 8;
      end
      return -1;
   endfunction

   function automatic void give(input int k);
      m_owner = k;
      m_ptr   = (k + 1) % 8;
      m_held  = 1;
   endfunction

   function automatic void model_step(input logic r_rst, input logic [7:0] r_req);
      logic [7:0] others;
      int k;
      if (r_rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
      end else if (m_owner < 0) begin
         k = first_from(r_req, m_ptr);
         if (k >= 0) give(k);
      end else begin
         others = r_req;
         others[m_owner] = 1'b0;
         if (!r_req[m_owner]) begin
            k = first_from(others, m_ptr);
            if (k >= 0) give(k);
            else m_owner = -1;
         end
`ifdef ARB_HOLD_LIMIT_EN
         else if (m_held >= MAX_HOLD && others != 8'h00) begin
            give(first_from(others, m_ptr));
         end
`endif
         else if (m_held < MAX_HOLD) begin
            m_held++;
         end
      end
   endfunction

   function automatic void add(input logic r, input logic [7:0] q, input logic [7:0] g,
                               input logic [2:0] id, input logic v);
      vec_t e;
      e.rst = r; e.req = q; e.gnt = g; e.id = id; e.valid = v;
      vecs.push_back(e);
   endfunction

   task automatic apply(input logic r_rst, input logic [7:0] r_req);
      rst = r_rst;
      req = r_req;
      @(posedge clk);
      model_step(r_rst, r_req);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] eg, input logic [2:0] eid, input logic ev);
      checks++;
      if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev) begin
         errors++;
         $display("FAIL %s @%0t: got gnt=%h gnt_id=%0d gnt_valid=%b, expected gnt=%h gnt_id=%0d gnt_valid=%b",
                  name, $time, gnt, gnt_id, gnt_valid, eg, eid, ev);
      end
   endtask

   task automatic check_model(input string name);
      if (m_owner < 0) check(name, 8'h00, 3'd0, 1'b0);
      else check(name, 8'h01 << m_owner, 3'(m_owner), 1'b1);
   endtask

   initial begin
      logic [7:0] r;
      logic       rr;

      // Reset with all requesting, then first grant goes to 0.
      add(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
      add(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
      add(1'b0, 8'hFF, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      // Single-requester sweep.
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 3; c++) add(1'b0, 8'h01 << k, 8'h01 << k, 3'(k), 1'b1);
         add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      end
      // Fairness between 0 and 7 with pointer wrap, no idle bubble.
      add(1'b0, 8'h81, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h81, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h80, 8'h80, 3'd7, 1'b1);
      add(1'b0, 8'h81, 8'h80, 3'd7, 1'b1);
      add(1'b0, 8'h01, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h81, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h80, 8'h80, 3'd7, 1'b1);
      add(1'b0, 8'h81, 8'h80, 3'd7, 1'b1);
      add(1'b0, 8'h01, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      // Park pointer at 3, then simultaneous requests 0,2,4 -> order 4,0,2.
      add(1'b0, 8'h04, 8'h04, 3'd2, 1'b1);
      add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      add(1'b0, 8'h15, 8'h10, 3'd4, 1'b1);
      add(1'b0, 8'h05, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h04, 8'h04, 3'd2, 1'b1);
      add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      // Reset while 5 holds; resume from pointer 0.
      add(1'b0, 8'h20, 8'h20, 3'd5, 1'b1);
      add(1'b1, 8'h21, 8'h00, 3'd0, 1'b0);
      add(1'b0, 8'h21, 8'h01, 3'd0, 1'b1);
      add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].req);
         check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid);
      end

      apply(1'b1, 8'h00);
`ifdef ARB_HOLD_LIMIT_EN
      for (int i = 0; i < 12; i++) begin
         apply(1'b0, 8'h03);
         check($sformatf("hold_rot%0d", i), 8'h01 << ((i / 4) % 2), 3'((i / 4) % 2), 1'b1);
      end
      apply(1'b1, 8'h00);
      for (int i = 0; i < 20; i++) begin
         apply(1'b0, 8'h01);
         check($sformatf("hold_alone%0d", i), 8'h01, 3'd0, 1'b1);
      end
`else
      for (int i = 0; i < 12; i++) begin
         apply(1'b0, 8'h03);
         check($sformatf("hold_nolimit%0d", i), 8'h01, 3'd0, 1'b1);
      end
`endif

      // Randomized traffic: mostly persistent requests with occasional bit flips and rare resets.
      apply(1'b1, 8'h00);
      r = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) r = 8'($urandom);
         else if ($urandom_range(0, 1) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
         else r = r;
         apply(rr, r);
         check_model($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares a single downstream resource among agents `d0`..`d7`. It accepts a request vector, issues a registered one-hot grant plus its 3-bit binary index (the 8-to-3 encoded form of the grant), and holds the grant until the holder releases. An optional hold-limit counter forces rotation so a holder cannot starve the other requesters.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per holder while others wait. Legal range 2..255. Used only with `ARB_HOLD_LIMIT_EN`.
- `clk`  input  1  Single clock. All state updates on its rising edge.
- `rst`  input  1  Synchronous, active-high reset.
- `req`  input  8  Request vector. Bit k is requester k. A requester holds its bit high while it wants or owns the resource.
- `gnt`  output  8  Registered one-hot grant. Always zero or exactly one bit set.
- `gnt_id`  output  3  Binary index of the set `gnt` bit. It is 0 when `gnt` is 0.
- `gnt_valid`  output  1  High when `gnt` is nonzero.

## Operation
- State machine:
  - IDLE: no grant outstanding.
  - GRANT: the `owner` register (3 bits) holds the current grantee.
- Priority pointer `ptr` (3 bits): search order is `ptr`, `ptr+1`, …, `ptr+7`, all modulo 8. After requester k is granted, `ptr` becomes k+1 mod 8, so 7 wraps to 0.
- IDLE → GRANT: on any edge where `req` is nonzero. Grant goes to the first set bit in search order.
- GRANT, holder's `req[owner]` still high (and no forced rotation): grant is held. `ptr` is unchanged.
- GRANT, holder's `req[owner]` sampled low:
  - If any other `req` bit is set, switch directly to the next requester in search order on the same edge, with no idle bubble.
  - Otherwise go to IDLE and clear `gnt`.
- A requester whose bit is low is never granted.
- A grant is never removed while its `req` bit is high, except by forced rotation or `rst`.
- Simultaneous new requests: only one is granted per edge. The others wait, with their order given by `ptr`.
- `gnt_id` and `gnt_valid` are decoded from `owner`/state registers, so all three outputs change on the same edge.
- Reset values: state IDLE, `ptr` 0, `owner` 0, hold counter 0, `gnt` 8'h00, `gnt_id` 3'd0, `gnt_valid` 0.
- Reset mid-grant: all outputs clear on the reset edge regardless of `req`. Arbitration resumes from `ptr`=0 on the first edge with `rst` low.

## Timing
- Request to grant latency: 1 cycle. If `req` is set before edge N and the arbiter is idle, `gnt` is valid after edge N.
- Release to re-grant: 1 cycle. If the holder drops `req` before edge N, the new `gnt` is valid after edge N.
- Release to idle: 1 cycle. `gnt` is zero after edge N.
- The holder sees `gnt` high for at least one full cycle before the release takes effect.
- No combinational path from `req` to any output.

## Configuration
- Macro: `ARB_HOLD_LIMIT_EN`.
- Defined:
  - An 8-bit hold counter resets to 0 on every new grant and increments each cycle the grant is held.
  - When the counter equals `MAX_HOLD-1` and any other `req` bit is set, the next edge rotates the grant to the next requester in search order, even if the holder's `req` is still high.
  - If no other requester is waiting, the holder keeps the grant and the counter saturates at `MAX_HOLD-1`.
  - A preempted holder re-enters normal round-robin order.
- Not defined:
  - The counter logic is removed.
  - A holder keeps the grant as long as its `req` is high.
  - `MAX_HOLD` is ignored.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 2 cycles with `req`=8'hFF.
  - Required: `gnt`=00, `gnt_id`=0, `gnt_valid`=0 during reset.
  - Required: one cycle after `rst` drops, `gnt`=01, `gnt_id`=0.
- Single requester sweep:
  - Stimulus: for k=0..7, pulse `req` = 1<<k for 3 cycles, then `req`=0.
  - Required: `gnt`=1<<k and `gnt_id`=k one cycle after assertion.
  - Required: `gnt`=00 one cycle after release.
- Round-robin fairness and wrap:
  - Stimulus: hold `req`=8'h81; each holder drops its bit for one cycle after 2 granted cycles, then re-raises it.
  - Required: grants alternate `gnt_id` 0,7,0,7 with no idle cycle between.
  - Required: `ptr` wraps from 7 to 0.
- Simultaneous requests:
  - Stimulus: from idle with `ptr`=3, set `req`=8'h15 (bits 0, 2, 4); the holder releases after 1 cycle each time.
  - Required: grant order 4, then 0, then 2.
- Reset mid-grant:
  - Stimulus: requester 5 is granted; assert `rst` for 1 cycle with `req`=8'h21 still set.
  - Required: outputs clear on the reset edge.
  - Required: the next grant is `gnt_id`=0.
- Hold limit (`ARB_HOLD_LIMIT_EN`, `MAX_HOLD`=4):
  - Stimulus: `req`=8'h03 held constantly.
  - Required: `gnt_id` sequence is 0 for 4 cycles, 1 for 4 cycles, 0 for 4 cycles.
  - Stimulus: repeat with only bit 0 set.
  - Required: the grant is held indefinitely.
  - Required without the macro: with `req`=8'h03 held, grant stays on 0 forever.
